// File: rtl/led_pattern_gen_if.sv
// LED pattern generator bus: per-channel mode/brightness in, tick and LED drive out.
interface led_pattern_gen_if #(
  parameter int NUM_CH   = 4,
  parameter int PWM_BITS = 8
);
  logic [2*NUM_CH-1:0]        MODE;
  logic [PWM_BITS*NUM_CH-1:0] DUTY;
  logic                       TICK;
  logic [NUM_CH-1:0]          LED;

  // Control logic side: drives modes and brightness, observes the pins.
  modport master (output MODE, DUTY, input TICK, LED);
  // Generator side.
  modport slave  (input MODE, DUTY, output TICK, LED);
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: OFF / ON / BLINK / BREATHE per channel, sharing one
// prescaled timing tick, one PWM counter, one blink phase and one breathe level.
module led_pattern_gen #(
  parameter int CLK_FREQ          = 100_000_000,
  parameter int TICK_HZ           = 1_000,
  parameter int NUM_CH            = 4,
  parameter int PWM_BITS          = 8,
  parameter int HALF_PERIOD_TICKS = 500
) (
  input logic              CLK,
  input logic              RST,
  led_pattern_gen_if.slave bus
);

  localparam int DIV       = CLK_FREQ / TICK_HZ;
  localparam int PRESC_W   = $clog2(DIV);
  localparam int BLINK_W   = (HALF_PERIOD_TICKS > 1) ? $clog2(HALF_PERIOD_TICKS) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(HALF_PERIOD_TICKS - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX  = '1;

  logic [PRESC_W-1:0]  presc_reg;
  logic                tick_reg;
  logic [PWM_BITS-1:0] pwm_reg;
  logic [BLINK_W-1:0]  blink_cnt_reg;
  logic                phase_reg;
  logic [PWM_BITS-1:0] level_reg;
  logic                dir_down_reg;
  logic [NUM_CH-1:0]   led_reg;
  logic [NUM_CH-1:0]   led_next;

  // Brightness compare; all-ones is a true 100% rather than (2^N-1)/2^N.
  function automatic logic level_on(input logic [PWM_BITS-1:0] lvl,
                                    input logic [PWM_BITS-1:0] pwm);
    return (lvl == LEVEL_MAX) || (pwm < lvl);
  endfunction

  // Prescaler and registered tick: TICK pulses the cycle after the count hits DIV-1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg  <= (presc_reg == PRESC_LAST);
      presc_reg <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
    end
  end

  // Free-running PWM counter, wraps naturally at all-ones.
  always_ff @(posedge CLK) begin
    if (RST) pwm_reg <= '0;
    else     pwm_reg <= pwm_reg + 1'b1;
  end

  // Blink half-period counter; the shared phase toggles at each wrap so all
  // BLINK channels stay phase-locked.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (tick_reg) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  // Breathe triangle: level holds for one tick at each end while direction flips.
  always_ff @(posedge CLK) begin
    if (RST) begin
      level_reg    <= '0;
      dir_down_reg <= 1'b0;
    end else if (tick_reg) begin
      if (!dir_down_reg) begin
        if (level_reg == LEVEL_MAX) dir_down_reg <= 1'b1;
        else                        level_reg    <= level_reg + 1'b1;
      end else begin
        if (level_reg == '0) dir_down_reg <= 1'b0;
        else                 level_reg    <= level_reg - 1'b1;
      end
    end
  end

  // Per-channel mode decode.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]          mode_ch;
    logic [PWM_BITS-1:0] duty_ch;
    logic                on_ch;

    assign mode_ch = bus.MODE[2*gi +: 2];
    assign duty_ch = bus.DUTY[PWM_BITS*gi +: PWM_BITS];

    // Select the channel's drive from its mode; DUTY is ignored in BREATHE.
    always_comb begin
      on_ch = 1'b0;
      case (mode_ch)
        2'b01:   on_ch = level_on(duty_ch, pwm_reg);
        2'b10:   on_ch = phase_reg & level_on(duty_ch, pwm_reg);
        2'b11:   on_ch = level_on(level_reg, pwm_reg);
        default: on_ch = 1'b0;
      endcase
    end

    assign led_next[gi] = on_ch;
  end

  // Register the pin drive: one cycle from counter state and MODE/DUTY to LED.
  always_ff @(posedge CLK) begin
    if (RST) led_reg <= '0;
    else     led_reg <= led_next;
  end

  assign bus.TICK = tick_reg;
  assign bus.LED  = led_reg;

endmodule
